// File: rtl/sevseg_mux_blink.sv
// rtl/sevseg_mux_blink.sv - time-multiplexed hex 7-seg driver with blanking, blink and frame-synced updates
module sevseg_mux_blink #(
    parameter int NUM_DIGITS   = 2,
    parameter int REFRESH_DIV  = 24000,
    parameter int BLANK_CYCLES = 48,
    parameter int BLINK_DIV    = 5000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   digits_i,
    input  logic                      load,
    input  logic [NUM_DIGITS-1:0]     blink_en,
    output logic [6:0]                segment,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic                      frame_done,
    output logic                      blink_phase
);

    localparam int SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SLOT_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]        dig_idx;
    logic [BLINK_W-1:0]      blink_cnt;
    logic [4*NUM_DIGITS-1:0] staging;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    pending;

    logic                    boundary;
    logic                    cur_blink;
    logic [3:0]              cur_nib;
    logic [NUM_DIGITS-1:0]   anode_nxt;
    logic [6:0]              segment_nxt;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    assign boundary = (slot_cnt == SLOT_LAST) && (dig_idx == IDX_LAST);

    // Digit select by comparison keeps indexing in range for any NUM_DIGITS
    always_comb begin
        cur_blink   = 1'b0;
        cur_nib     = 4'h0;
        anode_nxt   = '1;
        segment_nxt = 7'h7F;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (dig_idx == IDX_W'(k)) begin
                cur_blink = blink_en[k];
                cur_nib   = shadow[4*k +: 4];
            end
        end
        if (int'(slot_cnt) >= BLANK_CYCLES && !(cur_blink && blink_phase)) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                anode_nxt[k] = (dig_idx != IDX_W'(k));
            end
            segment_nxt = decode(cur_nib);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt    <= '0;
            dig_idx     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            staging     <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            anode       <= '1;
            segment     <= 7'h7F;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= boundary;
            anode      <= anode_nxt;
            segment    <= segment_nxt;

            if (slot_cnt == SLOT_LAST) begin
                slot_cnt <= '0;
                dig_idx  <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end

            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            // Shadow only changes on the frame boundary so a frame never mixes two loads
            if (load) begin
                staging <= digits_i;
            end
            if (boundary && load) begin
                shadow  <= digits_i;
                pending <= 1'b0;
            end else if (boundary && pending) begin
                shadow  <= staging;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sevseg_mux_blink.sv
// tb/tb_sevseg_mux_blink.sv - directed self-checking bench for sevseg_mux_blink
module tb_sevseg_mux_blink;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits = 16'h0;
    logic        load = 1'b0;
    logic [3:0]  blink_en = 4'h0;
    logic [6:0]  segment;
    logic [3:0]  anode;
    logic        frame_done;
    logic        blink_phase;

    logic [3:0]  digits1 = 4'h7;
    logic        load1 = 1'b0;
    logic [0:0]  blink_en1 = 1'b0;
    logic [6:0]  segment1;
    logic [0:0]  anode1;
    logic        frame_done1;
    logic        blink_phase1;

    int          n;
    int          vectors = 0;
    int          miscompares = 0;
    bit          phase2 = 1'b0;
    logic [6:0]  seg_tab [16];

    sevseg_mux_blink #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .BLINK_DIV(40)
    ) u_dut (
        .clk(clk), .reset(reset), .digits_i(digits), .load(load), .blink_en(blink_en),
        .segment(segment), .anode(anode), .frame_done(frame_done), .blink_phase(blink_phase)
    );

    sevseg_mux_blink #(
        .NUM_DIGITS(1), .REFRESH_DIV(8), .BLANK_CYCLES(2), .BLINK_DIV(40)
    ) u_one (
        .clk(clk), .reset(reset), .digits_i(digits1), .load(load1), .blink_en(blink_en1),
        .segment(segment1), .anode(anode1), .frame_done(frame_done1), .blink_phase(blink_phase1)
    );

    always #5 clk = ~clk;

    // Edges since reset release; all expected values are derived from it
    always @(posedge clk or posedge reset) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @n=%0d: got %h expected %h", tag, n, got, exp);
        end
    endtask

    function automatic logic [15:0] shadow_exp(input int nn);
        int f;
        f = (nn - 1) / 32;
        if (phase2) return 16'h0000;
        case (f)
            0:       return 16'h0000;
            1, 2:    return 16'hF8A1;
            3, 4:    return 16'h5678;
            default: return 16'hCDEB;
        endcase
    endfunction

    task automatic check_cycle();
        int         s, d;
        bit         ph, lit;
        logic [15:0] sh;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        s   = (n - 1) % 8;
        d   = ((n - 1) / 8) % 4;
        ph  = (((n - 1) / 40) % 2) == 1;
        sh  = shadow_exp(n);
        lit = (s >= 2) && !(blink_en[d] && ph);
        exp_an  = lit ? ~(4'b0001 << d) : 4'hF;
        exp_seg = lit ? seg_tab[sh[4*d +: 4]] : 7'h7F;
        check("anode", anode, exp_an);
        check("segment", segment, exp_seg);
        check("frame_done", frame_done, (n % 32) == 0);
        check("blink_phase", blink_phase, (n / 40) % 2);
        check("one_anode", anode1, (s >= 2) ? 0 : 1);
        check("one_segment", segment1, (s >= 2) ? seg_tab[0] : 7'h7F);
        check("one_frame_done", frame_done1, (n % 8) == 0);
    endtask

    task automatic check_reset_state();
        check("rst_anode", anode, 4'hF);
        check("rst_segment", segment, 7'h7F);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_blink_phase", blink_phase, 1'b0);
        check("rst_one_anode", anode1, 1'b1);
    endtask

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

        repeat (2) @(negedge clk);
        check_reset_state();
        reset = 1'b0;

        // Loads at idle, mid-frame twice, and on a boundary; blink on digit 2 late in the run
        for (int i = 0; i < 224; i++) begin
            @(negedge clk);
            check_cycle();
            load     = (n == 5) || (n == 74) || (n == 84) || (n == 159);
            digits   = (n == 5)  ? 16'hF8A1 :
                       (n == 74) ? 16'h1234 :
                       (n == 84) ? 16'h5678 :
                       (n == 159) ? 16'hCDEB : 16'h0000;
            blink_en = (n >= 160 && n < 224) ? 4'b0100 : 4'b0000;
        end

        @(posedge clk);
        #2;
        reset    = 1'b1;
        phase2   = 1'b1;
        load     = 1'b0;
        blink_en = 4'b0000;
        #1;
        check_reset_state();
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
